// File: rtl/uart_rx_oversampled.sv
// Majority-voting UART receiver: three samples per bit, false-start rejection,
// optional parity, and framing-error / break reporting into the RX FIFO path.
module uart_rx_oversampled #(
    parameter int unsigned C_PARITY  = 0,      // 0 none, 1 odd, 2 even; 3 is not a legal mode
    parameter logic [15:0] C_MIN_DIV = 16'd4
) (
    input  logic        uart_clock_i,
    input  logic        uart_reset_i,
    input  logic [15:0] bauddiv_i,
    input  logic        rx_en_i,
    input  logic        rx_i,
    output logic [7:0]  rx_byte_o,
    output logic        rx_o,
    output logic        rx_busy_o,
    output logic        frame_err_o,
    output logic        parity_err_o,
    output logic        break_o,
    output logic [2:0]  state_o
);

    // Handshake: rx_o is a valid-only strobe with no ready; rx_byte_o is valid in
    // the cycle rx_o is high and holds until the next good byte. No back-pressure.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic HAS_PAR = (C_PARITY != 32'd0);
    localparam logic ODD_PAR = (C_PARITY == 32'd1);

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        rx_s_q, rx_s_d;
    logic        rx_p_q, rx_p_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [15:0] half_q, half_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  votes_q, votes_d;
    logic        bit_val_q, bit_val_d;
    logic        par_bit_q, par_bit_d;
    logic        par_bad_q, par_bad_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_pulse_q, rx_pulse_d;
    logic        frame_err_q, frame_err_d;
    logic        parity_err_q, parity_err_d;
    logic        break_q, break_d;

    logic        start_cond;
    logic [15:0] div_eff;
    logic        bit_end;
    logic        at_vote;
    logic        vote_now;
    logic        stop_decide;
    logic        is_break;

    assign start_cond  = ~rx_s_q & rx_p_q;
    assign div_eff     = (bauddiv_i < C_MIN_DIV) ? C_MIN_DIV : bauddiv_i;
    assign bit_end     = (cnt_q == div_q - 16'd1);
    assign at_vote     = (cnt_q == half_q + 16'd1);
    // Third sample is taken live so the vote is ready on the h+1 cycle itself.
    assign vote_now    = (votes_q[1] & votes_q[0]) | (votes_q[1] & rx_s_q) | (votes_q[0] & rx_s_q);
    assign stop_decide = (state_q == S_STOP) && at_vote;
    assign is_break    = (shift_q == 8'h00) && (!HAS_PAR || !par_bit_q) && !vote_now;

    // Register process: every flop in the block.
    always_ff @(posedge uart_clock_i) begin
        if (uart_reset_i) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_p_q       <= 1'b1;
            cnt_q        <= '0;
            div_q        <= C_MIN_DIV;
            half_q       <= C_MIN_DIV >> 1;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            votes_q      <= '0;
            bit_val_q    <= 1'b0;
            par_bit_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            rx_byte_q    <= '0;
            rx_pulse_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            rx_p_q       <= rx_p_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            half_q       <= half_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            votes_q      <= votes_d;
            bit_val_q    <= bit_val_d;
            par_bit_q    <= par_bit_d;
            par_bad_q    <= par_bad_d;
            rx_byte_q    <= rx_byte_d;
            rx_pulse_q   <= rx_pulse_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_q      <= break_d;
        end
    end

    // Next-state process.
    always_comb begin
        state_d = state_q;
        if (!rx_en_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (start_cond) state_d = S_START;
                S_START:  if (bit_end) state_d = (at_vote ? vote_now : bit_val_q) ? S_IDLE : S_DATA;
                S_DATA:   if (bit_end && bit_idx_q == 3'd7) state_d = HAS_PAR ? S_PARITY : S_STOP;
                S_PARITY: if (bit_end) state_d = S_STOP;
                S_STOP:   if (at_vote) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: synchronizer, bit timing, voting, shift register and parity.
    always_comb begin
        sync1_d   = rx_i;
        rx_s_d    = sync1_q;
        rx_p_d    = rx_s_q;
        div_d     = div_q;
        half_d    = half_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        votes_d   = votes_q;
        bit_val_d = at_vote ? vote_now : bit_val_q;
        par_bit_d = par_bit_q;
        par_bad_d = par_bad_q;

        if (state_d != state_q || state_q == S_IDLE || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        if (cnt_q == half_q - 16'd1 || cnt_q == half_q) begin
            votes_d = {votes_q[0], rx_s_q};
        end

        // Divisor is frozen for the whole frame once the start edge is seen.
        if (state_q == S_IDLE && state_d == S_START) begin
            div_d  = div_eff;
            half_d = div_eff >> 1;
        end

        case (state_q)
            S_IDLE: begin
                shift_d   = '0;
                bit_idx_d = '0;
            end
            S_START: begin
                bit_idx_d = '0;
                par_bit_d = 1'b0;
                par_bad_d = 1'b0;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = {bit_val_d, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    par_bit_d = bit_val_d;
                    par_bad_d = (^shift_q) ^ bit_val_d ^ ODD_PAR;
                end
            end
            default: ;
        endcase

        if (!rx_en_i) begin
            cnt_d     = '0;
            shift_d   = '0;
            bit_idx_d = '0;
        end
    end

    // Output process: one outcome per frame, chosen at the STOP decision point.
    always_comb begin
        rx_byte_d    = rx_byte_q;
        rx_pulse_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        break_d      = 1'b0;
        if (rx_en_i && stop_decide) begin
            if (is_break) begin
                break_d = 1'b1;
            end else if (!vote_now) begin
                frame_err_d = 1'b1;
            end else if (par_bad_q) begin
                parity_err_d = 1'b1;
            end else begin
                rx_pulse_d = 1'b1;
                rx_byte_d  = shift_q;
            end
        end
    end

    assign rx_byte_o    = rx_byte_q;
    assign rx_o         = rx_pulse_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign break_o      = break_q;
    assign rx_busy_o    = (state_q != S_IDLE);
    assign state_o      = state_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: one no-parity and one even-parity
// instance, frames driven bit by bit, outcomes logged with their cycle index.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bd0 = 16'd16;
    logic [15:0] bd2 = 16'd16;
    logic        en0 = 1'b1;
    logic        en2 = 1'b1;
    logic        rx0 = 1'b1;
    logic        rx2 = 1'b1;
    logic [7:0]  byte0, byte2;
    logic        v0, v2, busy0, busy2, fe0, fe2, pe0, pe2, bk0, bk2;
    logic [2:0]  st0, st2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] exp_q[$];

    // Outcome logs, written only by the monitor.
    int         rx_n0 = 0, fe_n0 = 0, pe_n0 = 0, bk_n0 = 0, ev_cyc0 = 0;
    int         rx_n2 = 0, fe_n2 = 0, pe_n2 = 0, bk_n2 = 0, ev_cyc2 = 0;
    int         rx_cyc0[0:63];
    int         rx_cyc2[0:63];
    logic [7:0] rx_b0[0:63];
    logic [7:0] rx_b2[0:63];

    uart_rx_oversampled #(.C_PARITY(0), .C_MIN_DIV(16'd4)) dut0 (
        .uart_clock_i(clk), .uart_reset_i(rst), .bauddiv_i(bd0), .rx_en_i(en0), .rx_i(rx0),
        .rx_byte_o(byte0), .rx_o(v0), .rx_busy_o(busy0), .frame_err_o(fe0),
        .parity_err_o(pe0), .break_o(bk0), .state_o(st0)
    );

    uart_rx_oversampled #(.C_PARITY(2), .C_MIN_DIV(16'd4)) dut2 (
        .uart_clock_i(clk), .uart_reset_i(rst), .bauddiv_i(bd2), .rx_en_i(en2), .rx_i(rx2),
        .rx_byte_o(byte2), .rx_o(v2), .rx_busy_o(busy2), .frame_err_o(fe2),
        .parity_err_o(pe2), .break_o(bk2), .state_o(st2)
    );

    // Clock / cycle index block: cyc equals the index of the latest posedge.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0) begin
            rx_cyc0[rx_n0[5:0]] <= cyc;
            rx_b0[rx_n0[5:0]]   <= byte0;
            rx_n0               <= rx_n0 + 1;
        end
        if (fe0) fe_n0 <= fe_n0 + 1;
        if (pe0) pe_n0 <= pe_n0 + 1;
        if (bk0) bk_n0 <= bk_n0 + 1;
        if (fe0 | pe0 | bk0) ev_cyc0 <= cyc;
        if (v2) begin
            rx_cyc2[rx_n2[5:0]] <= cyc;
            rx_b2[rx_n2[5:0]]   <= byte2;
            rx_n2               <= rx_n2 + 1;
        end
        if (fe2) fe_n2 <= fe_n2 + 1;
        if (pe2) pe_n2 <= pe_n2 + 1;
        if (bk2) bk_n2 <= bk_n2 + 1;
        if (fe2 | pe2 | bk2) ev_cyc2 <= cyc;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation still running at cycle %0d, limit 40000", cyc);
        $fatal(1);
    end

    // Driver tasks. All are entered 1 time unit after a posedge.
    task automatic drive_bit(input int which, input logic v, input int n);
        if (which == 0) rx0 = v; else rx2 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx0 = 1'b1;
        rx2 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // t0 is the index of the first posedge that samples the start bit.
    task automatic send_frame(input int which, input logic [7:0] data, input int d,
                              input logic has_par, input logic par_bit, input logic stop_bit,
                              output int t0);
        t0 = cyc + 1;
        drive_bit(which, 1'b0, d);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i], d);
        if (has_par) drive_bit(which, par_bit, d);
        drive_bit(which, stop_bit, d);
        if (which == 0) rx0 = 1'b1; else rx2 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (byte0 !== 8'h00) begin bad++; $display("FAIL reset_byte0: got %h want 00", byte0); end
        total++; if ({v0, busy0, fe0, pe0, bk0} !== 5'b0) begin bad++; $display("FAIL reset_flags0: got %b want 00000", {v0, busy0, fe0, pe0, bk0}); end
        total++; if (st0 !== 3'd0) begin bad++; $display("FAIL reset_state0: got %0d want 0", st0); end
        total++; if (byte2 !== 8'h00) begin bad++; $display("FAIL reset_byte2: got %h want 00", byte2); end
        total++; if ({v2, busy2, fe2, pe2, bk2} !== 5'b0) begin bad++; $display("FAIL reset_flags2: got %b want 00000", {v2, busy2, fe2, pe2, bk2}); end
    endtask

    task automatic test_basic();
        int n, e, t0, k;
        n = rx_n0; e = fe_n0 + pe_n0 + bk_n0; k = n;
        send_frame(0, 8'h55, 16, 1'b0, 1'b0, 1'b1, t0);
        idle(40);
        total++; if (rx_n0 - n !== 1) begin bad++; $display("FAIL basic_count: got %0d want 1", rx_n0 - n); end
        total++; if (rx_cyc0[k[5:0]] !== t0 + 156) begin bad++; $display("FAIL basic_latency: got %0d want %0d", rx_cyc0[k[5:0]] - t0, 156); end
        total++; if (rx_b0[k[5:0]] !== 8'h55) begin bad++; $display("FAIL basic_byte: got %h want 55", rx_b0[k[5:0]]); end
        total++; if (fe_n0 + pe_n0 + bk_n0 - e !== 0) begin bad++; $display("FAIL basic_errors: got %0d want 0", fe_n0 + pe_n0 + bk_n0 - e); end
    endtask

    task automatic test_back_to_back();
        int n, ta, tb, k;
        n = rx_n0;
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h00);
        send_frame(0, 8'hA3, 16, 1'b0, 1'b0, 1'b1, ta);
        send_frame(0, 8'h00, 16, 1'b0, 1'b0, 1'b1, tb);
        idle(40);
        total++; if (rx_n0 - n !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", rx_n0 - n); end
        for (int i = 0; i < 2; i++) begin
            logic [7:0] want;
            k = n + i;
            want = exp_q.pop_front();
            total++; if (rx_b0[k[5:0]] !== want) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_b0[k[5:0]], want); end
        end
        k = n;
        total++; if (rx_cyc0[k[5:0]] !== ta + 156) begin bad++; $display("FAIL b2b_first_latency: got %0d want 156", rx_cyc0[k[5:0]] - ta); end
        total++; if (rx_cyc0[(k + 1) % 64] - rx_cyc0[k[5:0]] !== 160) begin bad++; $display("FAIL b2b_spacing: got %0d want 160", rx_cyc0[(k + 1) % 64] - rx_cyc0[k[5:0]]); end
    endtask

    task automatic test_glitch();
        int n, e, hi, first;
        n = rx_n0; e = fe_n0 + pe_n0 + bk_n0; hi = 0; first = -1;
        for (int i = 0; i < 40; i++) begin
            rx0 = (i < 5) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (busy0) begin
                hi++;
                if (first < 0) first = i;
            end
        end
        total++; if (hi !== 16) begin bad++; $display("FAIL glitch_busy_len: got %0d want 16", hi); end
        total++; if (first !== 2) begin bad++; $display("FAIL glitch_busy_rise: got %0d want 2", first); end
        total++; if (rx_n0 + fe_n0 + pe_n0 + bk_n0 - n - e !== 0) begin bad++; $display("FAIL glitch_pulses: got %0d want 0", rx_n0 + fe_n0 + pe_n0 + bk_n0 - n - e); end
        total++; if (st0 !== 3'd0) begin bad++; $display("FAIL glitch_state: got %0d want 0", st0); end
    endtask

    task automatic test_break();
        int n, b, f, t0, k;
        n = rx_n0; b = bk_n0; f = fe_n0;
        t0 = cyc + 1;
        drive_bit(0, 1'b0, 640);
        total++; if (bk_n0 - b !== 1) begin bad++; $display("FAIL break_count: got %0d want 1", bk_n0 - b); end
        total++; if (ev_cyc0 !== t0 + 156) begin bad++; $display("FAIL break_latency: got %0d want 156", ev_cyc0 - t0); end
        total++; if ((rx_n0 - n) + (fe_n0 - f) !== 0) begin bad++; $display("FAIL break_other: got %0d want 0", (rx_n0 - n) + (fe_n0 - f)); end
        idle(32);
        k = rx_n0;
        send_frame(0, 8'h3C, 16, 1'b0, 1'b0, 1'b1, t0);
        idle(40);
        total++; if (rx_n0 - k !== 1) begin bad++; $display("FAIL break_after_count: got %0d want 1", rx_n0 - k); end
        total++; if (rx_b0[k[5:0]] !== 8'h3C) begin bad++; $display("FAIL break_after_byte: got %h want 3c", rx_b0[k[5:0]]); end
    endtask

    task automatic test_div_latch();
        int t0, k;
        logic [7:0] data;
        data = 8'hC5; k = rx_n0;
        bd0 = 16'd16;
        t0 = cyc + 1;
        drive_bit(0, 1'b0, 16);
        bd0 = 16'd5;
        for (int i = 0; i < 8; i++) drive_bit(0, data[i], 16);
        drive_bit(0, 1'b1, 16);
        bd0 = 16'd16;
        idle(40);
        total++; if (rx_n0 - k !== 1) begin bad++; $display("FAIL latch_count: got %0d want 1", rx_n0 - k); end
        total++; if (rx_cyc0[k[5:0]] !== t0 + 156) begin bad++; $display("FAIL latch_latency: got %0d want 156", rx_cyc0[k[5:0]] - t0); end
        total++; if (rx_b0[k[5:0]] !== 8'hC5) begin bad++; $display("FAIL latch_byte: got %h want c5", rx_b0[k[5:0]]); end
    endtask

    task automatic test_min_div();
        int t0, k;
        k = rx_n0;
        bd0 = 16'd2;
        send_frame(0, 8'hF0, 4, 1'b0, 1'b0, 1'b1, t0);
        idle(20);
        bd0 = 16'd16;
        total++; if (rx_n0 - k !== 1) begin bad++; $display("FAIL mindiv_count: got %0d want 1", rx_n0 - k); end
        total++; if (rx_cyc0[k[5:0]] !== t0 + 42) begin bad++; $display("FAIL mindiv_latency: got %0d want 42", rx_cyc0[k[5:0]] - t0); end
        total++; if (rx_b0[k[5:0]] !== 8'hF0) begin bad++; $display("FAIL mindiv_byte: got %h want f0", rx_b0[k[5:0]]); end
    endtask

    task automatic test_frame_err();
        int n, f, b, t0;
        n = rx_n0; f = fe_n0; b = bk_n0;
        send_frame(0, 8'h55, 16, 1'b0, 1'b0, 1'b0, t0);
        idle(40);
        total++; if (fe_n0 - f !== 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", fe_n0 - f); end
        total++; if (ev_cyc0 !== t0 + 156) begin bad++; $display("FAIL ferr_latency: got %0d want 156", ev_cyc0 - t0); end
        total++; if ((rx_n0 - n) + (bk_n0 - b) !== 0) begin bad++; $display("FAIL ferr_other: got %0d want 0", (rx_n0 - n) + (bk_n0 - b)); end
        total++; if (byte0 !== 8'hF0) begin bad++; $display("FAIL ferr_byte_hold: got %h want f0", byte0); end
    endtask

    task automatic test_disable();
        int n, e;
        n = rx_n0; e = fe_n0 + pe_n0 + bk_n0;
        drive_bit(0, 1'b0, 16);
        drive_bit(0, 1'b1, 16);
        drive_bit(0, 1'b0, 16);
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL dis_busy_before: got %b want 1", busy0); end
        en0 = 1'b0;
        @(posedge clk);
        #1;
        total++; if ({busy0, st0} !== 4'b0) begin bad++; $display("FAIL dis_idle: got busy=%b state=%0d want 0/0", busy0, st0); end
        for (int i = 0; i < 5; i++) drive_bit(0, 1'b0, 16);
        drive_bit(0, 1'b1, 16);
        drive_bit(0, 1'b1, 16);
        en0 = 1'b1;
        idle(40);
        total++; if (rx_n0 + fe_n0 + pe_n0 + bk_n0 - n - e !== 0) begin bad++; $display("FAIL dis_pulses: got %0d want 0", rx_n0 + fe_n0 + pe_n0 + bk_n0 - n - e); end
        total++; if (byte0 !== 8'hF0) begin bad++; $display("FAIL dis_byte_hold: got %h want f0", byte0); end
    endtask

    task automatic test_parity();
        int n, p, f, b, t0;
        n = rx_n2; p = pe_n2;
        send_frame(2, 8'h07, 16, 1'b1, 1'b0, 1'b1, t0);
        idle(40);
        total++; if (pe_n2 - p !== 1) begin bad++; $display("FAIL par_bad_count: got %0d want 1", pe_n2 - p); end
        total++; if (ev_cyc2 !== t0 + 172) begin bad++; $display("FAIL par_bad_latency: got %0d want 172", ev_cyc2 - t0); end
        total++; if (rx_n2 - n !== 0) begin bad++; $display("FAIL par_bad_rx: got %0d want 0", rx_n2 - n); end
        total++; if (byte2 !== 8'h00) begin bad++; $display("FAIL par_bad_byte_hold: got %h want 00", byte2); end
        n = rx_n2; p = pe_n2;
        send_frame(2, 8'h07, 16, 1'b1, 1'b1, 1'b1, t0);
        idle(40);
        total++; if ((rx_n2 - n !== 1) || (pe_n2 - p !== 0)) begin bad++; $display("FAIL par_good_count: got rx=%0d perr=%0d want 1/0", rx_n2 - n, pe_n2 - p); end
        total++; if (rx_cyc2[n[5:0]] !== t0 + 172) begin bad++; $display("FAIL par_good_latency: got %0d want 172", rx_cyc2[n[5:0]] - t0); end
        total++; if (rx_b2[n[5:0]] !== 8'h07) begin bad++; $display("FAIL par_good_byte: got %h want 07", rx_b2[n[5:0]]); end
        p = pe_n2; f = fe_n2;
        send_frame(2, 8'h07, 16, 1'b1, 1'b0, 1'b0, t0);
        idle(40);
        total++; if ({fe_n2 - f, pe_n2 - p} !== {32'd1, 32'd0}) begin bad++; $display("FAIL par_frame_prio: got ferr=%0d perr=%0d want 1/0", fe_n2 - f, pe_n2 - p); end
        b = bk_n2; f = fe_n2;
        send_frame(2, 8'h00, 16, 1'b1, 1'b0, 1'b0, t0);
        idle(40);
        total++; if ({bk_n2 - b, fe_n2 - f} !== {32'd1, 32'd0}) begin bad++; $display("FAIL par_break: got brk=%0d ferr=%0d want 1/0", bk_n2 - b, fe_n2 - f); end
        b = bk_n2; f = fe_n2;
        send_frame(2, 8'h00, 16, 1'b1, 1'b1, 1'b0, t0);
        idle(40);
        total++; if ({bk_n2 - b, fe_n2 - f} !== {32'd0, 32'd1}) begin bad++; $display("FAIL par_nobreak: got brk=%0d ferr=%0d want 0/1", bk_n2 - b, fe_n2 - f); end
    endtask

    task automatic test_reset_mid();
        int t0, k;
        logic [7:0] data;
        data = 8'h5A;
        drive_bit(0, 1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(0, data[i], 16);
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL rmid_busy_before: got %b want 1", busy0); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (byte0 !== 8'h00) begin bad++; $display("FAIL rmid_byte: got %h want 00", byte0); end
        total++; if ({v0, busy0, fe0, pe0, bk0, st0} !== 8'b0) begin bad++; $display("FAIL rmid_flags: got %b want 00000000", {v0, busy0, fe0, pe0, bk0, st0}); end
        rst = 1'b0;
        idle(32);
        k = rx_n0;
        send_frame(0, 8'h5A, 16, 1'b0, 1'b0, 1'b1, t0);
        idle(40);
        total++; if (rx_n0 - k !== 1) begin bad++; $display("FAIL rmid_count: got %0d want 1", rx_n0 - k); end
        total++; if (rx_cyc0[k[5:0]] !== t0 + 156) begin bad++; $display("FAIL rmid_latency: got %0d want 156", rx_cyc0[k[5:0]] - t0); end
        total++; if (rx_b0[k[5:0]] !== 8'h5A) begin bad++; $display("FAIL rmid_byte_after: got %h want 5a", rx_b0[k[5:0]]); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        idle(8);
        test_basic();
        test_back_to_back();
        test_glitch();
        test_break();
        test_div_latch();
        test_min_div();
        test_frame_err();
        test_disable();
        test_parity();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
